// File: rtl/debug_reg_dumper.sv
// debug_reg_dumper: walks a register index range over the datapath debug mux and streams each word out.
// Optional DBG_DUMP_CHECKSUM_EN appends an XOR checksum word after the last register word.
module debug_reg_dumper #(
  parameter int SEL_WIDTH     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  first_sel,
  input  logic [SEL_WIDTH-1:0]  last_sel,
  output logic [SEL_WIDTH-1:0]  dbg_sel,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]  out_index,
  output logic                  out_last,
  output logic                  out_csum,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, SEND, DONE} state_t;
  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  cur_q, cur_d, last_q, last_d, idx_q, idx_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d, olast_q, olast_d, fin;
  logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef DBG_DUMP_CHECKSUM_EN
  logic                  csum_q, csum_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  assign fin      = csum_q;
  assign out_csum = csum_q;
`else
  assign fin      = olast_q;
  assign out_csum = 1'b0;
`endif
  assign dbg_sel   = cur_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = idx_q;
  assign out_last  = olast_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    olast_d = olast_q;
`ifdef DBG_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        cur_d   = first_sel;
        last_d  = last_sel;
        cnt_d   = '0;
        state_d = SETTLE;
`ifdef DBG_DUMP_CHECKSUM_EN
        acc_d   = '0;
`endif
      end
      SETTLE: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = cnt_q == 3'(SETTLE_CYCLES - 1) ? CAPTURE : SETTLE;
      end
      CAPTURE: begin
        data_d  = dbg_data;
        idx_d   = cur_q;
        valid_d = 1'b1;
        state_d = SEND;
`ifdef DBG_DUMP_CHECKSUM_EN
        acc_d   = acc_q ^ dbg_data;
        olast_d = 1'b0;
        csum_d  = 1'b0;
`else
        olast_d = cur_q == last_q;
`endif
      end
      SEND: if (out_ready) begin
        valid_d = 1'b0;
        if (fin) state_d = DONE;
`ifdef DBG_DUMP_CHECKSUM_EN
        // checksum word goes out directly, no settle/capture needed
        else if (cur_q == last_q) begin
          valid_d = 1'b1;
          data_d  = acc_q;
          idx_d   = '0;
          olast_d = 1'b1;
          csum_d  = 1'b1;
        end
`endif
        else begin
          cur_d   = cur_q + SEL_WIDTH'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      olast_q <= 1'b0;
`ifdef DBG_DUMP_CHECKSUM_EN
      csum_q  <= 1'b0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      olast_q <= olast_d;
`ifdef DBG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
      acc_q   <= acc_d;
`endif
    end
  end
endmodule

// File: doc/debug_reg_dumper.md
Name: debug_reg_dumper

Overview:
Sequential reader for the register-file debug port exposed by the pipelined datapath (Debug_Source_select out, Debug_out back). On a start pulse, walks a contiguous range of register indices, captures each register value once the debug mux has settled, and streams the words out over a valid/ready interface. Sits between the datapath and a host-side debug/telemetry sink such as a UART bridge or trace buffer.

Parameters:
SEL_WIDTH, 4, width of the register index and debug select.
DATA_WIDTH, 32, register word width.
SETTLE_CYCLES, 1, clocks between driving dbg_sel and capturing dbg_data; legal range 1..7.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-low reset.
start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
first_sel  input  SEL_WIDTH  first register index; latched on an accepted start.
last_sel  input  SEL_WIDTH  last register index; latched on an accepted start.
dbg_sel  output  SEL_WIDTH  drives the datapath Debug_Source_select.
dbg_data  input  DATA_WIDTH  driven by the datapath Debug_out.
out_valid  output  1  out_data, out_index, out_last and out_csum are valid.
out_ready  input  1  sink accepts the word when out_valid && out_ready.
out_data  output  DATA_WIDTH  captured register word.
out_index  output  SEL_WIDTH  register index of out_data.
out_last  output  1  final word of the dump.
out_csum  output  1  current word is the checksum word; constant 0 without the macro.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, dbg_sel=0, out_valid=0, out_data=0, out_index=0, out_last=0, out_csum=0, busy=0, done=0, settle counter=0, checksum=0. Reset during any state aborts the dump immediately. No partial word is presented after reset.
- States: IDLE, SETTLE, CAPTURE, SEND, DONE.
- IDLE: on start=1, latch first_sel and last_sel, set cur=first_sel, dbg_sel=first_sel, clear the settle counter, and go to SETTLE. busy goes high the next cycle.
- SETTLE: the counter increments each cycle. When it reaches SETTLE_CYCLES-1, go to CAPTURE. dbg_sel holds cur.
- CAPTURE: one cycle. Register out_data=dbg_data and out_index=cur. out_last=(cur==last_sel) when the checksum feature is absent. Assert out_valid and go to SEND.
- Start-to-first-valid latency: SETTLE_CYCLES+1 cycles after the start edge. With SETTLE_CYCLES=1, start seen at edge N gives out_valid high after edge N+2.
- SEND: out_data, out_index, out_last and out_csum stay stable while out_valid && !out_ready. On handshake, deassert out_valid.
  - If the word just sent was the last word, go to DONE.
  - Otherwise set cur=cur+1 modulo 2^SEL_WIDTH, drive dbg_sel=cur, clear the counter, and go to SETTLE.
- Back-to-back words therefore take at least SETTLE_CYCLES+2 cycles each. The next out_valid rises no earlier than the cycle after the handshake.
- Wrap-around: if first_sel > last_sel, the index wraps from 2^SEL_WIDTH-1 to 0 and continues to last_sel. For first=14, last=1 the order is 14,15,0,1.
- first_sel==last_sel: exactly one register word.
- Word count = ((last_sel - first_sel) mod 2^SEL_WIDTH) + 1, so a full 16-register dump is first=0, last=15.
- DONE: done=1 for exactly one cycle, busy=0 from the next cycle, then return to IDLE. dbg_sel keeps its last value.
- start while busy (any state but IDLE) is ignored; it is not queued.
- start and reset low in the same cycle: reset wins.
- out_ready is ignored while out_valid=0.

Optional Feature:
DBG_DUMP_CHECKSUM_EN
- Defined:
  - A running checksum is cleared on an accepted start and XOR-accumulates every captured register word.
  - After the final register word is handshaken, the block goes straight to SEND with out_data=checksum, out_index=0, out_csum=1, out_last=1. This word needs no SETTLE or CAPTURE, so out_valid rises the cycle after that handshake.
  - out_last is 0 on all register words.
  - DONE follows the checksum handshake.
- Undefined: no checksum logic, out_csum tied to 0, out_last asserted on the final register word.

Test Plan:
1. Model regs R[i]=0xA0000000+i, SETTLE_CYCLES=1, first=0, last=15, out_ready=1 -> 16 words with index 0..15 and data 0xA0000000..0xA000000F, out_last only on index 15; done pulses once; busy falls the cycle after done.
2. first=14, last=1 -> indices 14,15,0,1 with the matching data; out_last on index 1; exactly 4 handshakes.
3. first=last=5, out_ready held 0 for 10 cycles after out_valid rises -> out_data=0xA0000005 held stable for all 10 cycles; a single handshake; done pulses 1 cycle later.
4. start pulsed again while busy during case 1 -> ignored: still 16 words and one done. Reset low at the word-3 SEND -> next cycle out_valid=0, busy=0, dbg_sel=0; no further words until a new start.
5. SETTLE_CYCLES=3, dbg_data model lagging dbg_sel by 2 cycles -> all captured words are correct; start-to-first-valid equals 4 cycles.
6. With DBG_DUMP_CHECKSUM_EN, first=0, last=3 -> 4 register words with out_last=0, then a fifth word with data 0x00000000 (the XOR of 0xA0000000..0xA0000003), out_csum=1, out_last=1, out_index=0.
